// File: rtl/inst_encoder_loader.sv
// RV32I descriptor encoder and instruction-memory loader.
// Ports: start/base_addr/word_cnt open a load; in_* is the descriptor
// stream (valid/ready); mem_*_I is the registered memory write port;
// format_out is the one-hot format of the written word; busy/done/err
// report load status.
module inst_encoder_loader #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [29:0]      base_addr,
  input  logic [CNT_W-1:0] word_cnt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [22:0]      in_type,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             mem_wen_I,
  output logic [29:0]      mem_addr_I,
  output logic [31:0]      mem_wdata_I,
  output logic [4:0]       format_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [4:0] FMT_R = 5'b10000;
  localparam logic [4:0] FMT_I = 5'b01000;
  localparam logic [4:0] FMT_S = 5'b00100;
  localparam logic [4:0] FMT_B = 5'b00010;
  localparam logic [4:0] FMT_J = 5'b00001;
  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [29:0]      addr_q, addr_d;
  logic             wen_q, wen_d;
  logic [29:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [4:0]       fmt_q, fmt_d;
  logic             err_q, err_d;

  logic        hs;
  logic        legal;
  logic [22:0] oh;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        shift;
  logic [4:0]  fmt;
  logic [31:0] word;

  // Exactly one bit set; illegal types are masked so the decoder
  // below only ever sees a true one-hot or zero.
  assign legal = (in_type != 23'd0) &&
                 ((in_type & (in_type - 23'd1)) == 23'd0);
  assign oh = legal ? in_type : 23'd0;

  always_comb begin
    op    = 7'h13;
    f3    = 3'd0;
    f7    = 7'h00;
    shift = 1'b0;
    fmt   = FMT_I;
    unique case (1'b1)
      oh[22]: begin op = 7'h6f; fmt = FMT_J; end
      oh[21]: begin op = 7'h67; end
      oh[20]: begin op = 7'h63; fmt = FMT_B; end
      oh[19]: begin op = 7'h63; f3 = 3'd1; fmt = FMT_B; end
      oh[18]: begin op = 7'h03; f3 = 3'd2; end
      oh[17]: begin op = 7'h23; f3 = 3'd2; fmt = FMT_S; end
      oh[16]: begin f3 = 3'd0; end
      oh[15]: begin f3 = 3'd2; end
      oh[14]: begin f3 = 3'd4; end
      oh[13]: begin f3 = 3'd6; end
      oh[12]: begin f3 = 3'd7; end
      oh[11]: begin f3 = 3'd1; shift = 1'b1; end
      oh[10]: begin f3 = 3'd5; shift = 1'b1; end
      oh[9]: begin
        f3 = 3'd5; f7 = 7'h20; shift = 1'b1;
      end
      oh[8]: begin op = 7'h33; fmt = FMT_R; end
      oh[7]: begin op = 7'h33; f7 = 7'h20; fmt = FMT_R; end
      oh[6]: begin op = 7'h33; f3 = 3'd1; fmt = FMT_R; end
      oh[5]: begin op = 7'h33; f3 = 3'd2; fmt = FMT_R; end
      oh[4]: begin op = 7'h33; f3 = 3'd4; fmt = FMT_R; end
      oh[3]: begin op = 7'h33; f3 = 3'd5; fmt = FMT_R; end
      oh[2]: begin
        op = 7'h33; f3 = 3'd5; f7 = 7'h20; fmt = FMT_R;
      end
      oh[1]: begin op = 7'h33; f3 = 3'd6; fmt = FMT_R; end
      oh[0]: begin op = 7'h33; f3 = 3'd7; fmt = FMT_R; end
      default: begin end
    endcase
  end

  always_comb begin
    word = NOP;
    unique case (fmt)
      FMT_R: word = {f7, in_rs2, in_rs1, f3, in_rd, op};
      FMT_I: begin
        if (shift) begin
          word = {f7, in_imm[4:0], in_rs1, f3, in_rd, op};
        end else begin
          word = {in_imm[11:0], in_rs1, f3, in_rd, op};
        end
      end
      FMT_S: word = {in_imm[11:5], in_rs2, in_rs1, f3,
                     in_imm[4:0], op};
      FMT_B: word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                     f3, in_imm[4:1], in_imm[11], op};
      FMT_J: word = {in_imm[20], in_imm[10:1], in_imm[11],
                     in_imm[19:12], in_rd, op};
      default: word = NOP;
    endcase
    if (!legal) word = NOP;
  end

  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q == S_LOAD);
  assign done     = (state_q == S_DONE);
  assign hs       = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    fmt_d   = fmt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = word_cnt;
          err_d   = 1'b0;
          state_d = (word_cnt == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (hs) begin
          wen_d   = 1'b1;
          waddr_d = addr_q;
          wdata_d = word;
          fmt_d   = legal ? fmt : FMT_I;
          addr_d  = addr_q + 30'd1;
          rem_d   = rem_q - 1'b1;
          if (!legal) err_d = 1'b1;
          if (rem_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      fmt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      fmt_q   <= fmt_d;
      err_q   <= err_d;
    end
  end

  assign mem_wen_I   = wen_q;
  assign mem_addr_I  = waddr_q;
  assign mem_wdata_I = wdata_q;
  assign format_out  = fmt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: vector table driven through loads,
// writes checked against a queue of expected {addr, word, format}.
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [29:0] base_addr;
  logic [15:0] word_cnt;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] in_type;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        mem_wen_I;
  logic [29:0] mem_addr_I;
  logic [31:0] mem_wdata_I;
  logic [4:0]  format_out;
  logic        busy, done, err;

  always #5 clk = ~clk;

  inst_encoder_loader #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .word_cnt(word_cnt),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_wen_I(mem_wen_I), .mem_addr_I(mem_addr_I),
    .mem_wdata_I(mem_wdata_I), .format_out(format_out),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [22:0] ty;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] wd;
    logic [4:0]  fmt;
  } vec_t;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [4:0]  f;
  } exp_t;

  localparam logic [4:0] R = 5'b10000;
  localparam logic [4:0] I = 5'b01000;
  localparam logic [4:0] S = 5'b00100;
  localparam logic [4:0] B = 5'b00010;
  localparam logic [4:0] J = 5'b00001;

  vec_t        tbl [18];
  exp_t        sbq [$];
  logic [29:0] exp_addr;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [22:0] oh(input int b);
    return 23'd1 << b;
  endfunction

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wen_I === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_wen", 64'(mem_addr_I), 64'hFFFF);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("addr", 64'(mem_addr_I), 64'(e.a));
        chk("wdata", 64'(mem_wdata_I), 64'(e.d));
        chk("format", 64'(format_out), 64'(e.f));
      end
    end
  end

  task automatic start_load(input logic [29:0] b,
                            input logic [15:0] c);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    word_cnt  = c;
    exp_addr  = b;
  endtask

  task automatic drive(input vec_t v);
    bit ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_type  = v.ty;
      in_rd    = v.rd;
      in_rs1   = v.rs1;
      in_rs2   = v.rs2;
      in_imm   = v.imm;
      if (in_ready) begin
        sbq.push_back('{exp_addr, v.wd, v.fmt});
        exp_addr = exp_addr + 30'd1;
        ok = 1'b1;
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
    end
  endtask

  task automatic finish_load(input logic exp_err);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      if (done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("ready_drop", 64'(in_ready), 64'd0);
    chk("err_at_done", 64'(err), 64'(exp_err));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("queue_drained", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    tbl[0]  = '{oh(8), 3, 1, 2, 0, 32'h002081B3, R};
    tbl[1]  = '{oh(7), 5, 6, 7, 0, 32'h407302B3, R};
    tbl[2]  = '{oh(20), 0, 1, 2, 8, 32'h00208463, B};
    tbl[3]  = '{oh(22), 1, 5, 6, 2048, 32'h001000EF, J};
    tbl[4]  = '{oh(17), 9, 1, 2, 4, 32'h0020A223, S};
    tbl[5]  = '{oh(9), 1, 1, 0, 3, 32'h4030D093, I};
    tbl[6]  = '{oh(16), 1, 0, 31, 32'hFFFFFFFF, 32'hFFF00093, I};
    tbl[7]  = '{oh(21), 0, 1, 0, 0, 32'h00008067, I};
    tbl[8]  = '{oh(18), 5, 2, 0, 8, 32'h00812283, I};
    tbl[9]  = '{oh(19), 0, 1, 0, 32'hFFFFFFFC, 32'hFE009EE3, B};
    tbl[10] = '{oh(4), 10, 11, 12, 0, 32'h00C5C533, R};
    tbl[11] = '{oh(11), 2, 3, 0, 32'h3F, 32'h01F19113, I};
    tbl[12] = '{oh(22), 0, 0, 0, 32'hFFFFFFFE, 32'hFFFFF06F, J};
    tbl[13] = '{23'h3, 3, 1, 2, 0, 32'h00000013, I};
    tbl[14] = '{23'h0, 3, 1, 2, 5, 32'h00000013, I};
    tbl[15] = '{oh(0), 1, 2, 3, 0, 32'h003170B3, R};
    tbl[16] = '{oh(2), 4, 5, 6, 0, 32'h4062D233, R};
    tbl[17] = '{oh(17), 0, 4, 3, 32'hFFFFFFF8, 32'hFE322C23, S};

    rst = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0;
    in_valid = 1'b0; in_type = '0; in_rd = '0; in_rs1 = '0;
    in_rs2 = '0; in_imm = '0; exp_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_wen", 64'(mem_wen_I), 64'd0);
    chk("rst_addr", 64'(mem_addr_I), 64'd0);
    chk("rst_wdata", 64'(mem_wdata_I), 64'd0);
    chk("rst_fmt", 64'(format_out), 64'd0);
    chk("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
    rst = 1'b0;

    start_load(30'h100, 16'd1);
    drive(tbl[0]);
    finish_load(1'b0);

    start_load(30'h200, 16'd5);
    for (int i = 1; i <= 5; i++) drive(tbl[i]);
    finish_load(1'b0);

    start_load(30'h3FFFFFFF, 16'd2);
    drive(tbl[6]);
    drive(tbl[7]);
    finish_load(1'b0);

    start_load(30'h1234, 16'd8);
    for (int i = 8; i <= 12; i++) drive(tbl[i]);
    for (int i = 15; i <= 17; i++) drive(tbl[i]);
    finish_load(1'b0);

    start_load(30'h80, 16'd3);
    drive(tbl[13]);
    drive(tbl[14]);
    drive(tbl[0]);
    finish_load(1'b1);
    idle(2);
    chk("err_sticky_idle", 64'(err), 64'd1);
    start_load(30'h0, 16'd0);
    @(negedge clk);
    start = 1'b0;
    chk("err_cleared", 64'(err), 64'd0);
    chk("cnt0_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("cnt0_done_low", 64'(done), 64'd0);

    start_load(30'h40, 16'd3);
    drive(tbl[1]);
    idle(1);
    @(negedge clk);
    in_valid  = 1'b0;
    start     = 1'b1;
    base_addr = 30'h999;
    word_cnt  = 16'd7;
    idle(1);
    chk("busy_in_gap", 64'(busy), 64'd1);
    drive(tbl[9]);
    idle(2);
    drive(tbl[4]);
    finish_load(1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      chk("idle_not_ready", 64'(in_ready), 64'd0);
    end
    idle(1);

    start_load(30'h500, 16'd4);
    drive(tbl[2]);
    drive(tbl[3]);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 64'({in_ready, mem_wen_I, busy, done,
        err}), 64'd0);
    chk("abort_data", 64'({mem_addr_I, mem_wdata_I, format_out}),
        64'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_type  = oh(8);
      chk("abort_no_ready", 64'(in_ready), 64'd0);
    end
    idle(2);
    chk("final_queue", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
